// File: rtl/ysyx_23060061_ifu.sv
// Instruction-fetch responder: validates a core pc request, issues one memory read, returns the word.
// Optional MWAIT watchdog is built only when YSYX_23060061_IFU_TIMEOUT_EN is defined.
module ysyx_23060061_ifu #(
    parameter int unsigned       ADDR_W = 32,
    parameter logic [ADDR_W-1:0] BASE   = ADDR_W'(32'h8000_0000),
    parameter logic [ADDR_W-1:0] SIZE   = ADDR_W'(32'h0800_0000)
`ifdef YSYX_23060061_IFU_TIMEOUT_EN
    ,
    parameter int unsigned       TIMEOUT = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_pc,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_inst,
    output logic [ADDR_W-1:0] rsp_pc,
    output logic              rsp_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rsp_valid,
    input  logic [31:0]       mem_rdata
);

    localparam int unsigned       INST_W = 32;
    localparam logic [INST_W-1:0] NOP    = 32'h0000_0013;

    // Window bounds carried at ADDR_W+1 bits so BASE+SIZE cannot wrap.
    localparam logic [ADDR_W:0] LO_EXT = {1'b0, BASE};
    localparam logic [ADDR_W:0] HI_EXT = LO_EXT + {1'b0, SIZE};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MREQ  = 3'd1,
        MWAIT = 3'd2,
        RESP  = 3'd3,
        DRAIN = 3'd4
    } state_t;

    state_t              state_q;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   pc_q;
    logic [INST_W-1:0]   inst_q;
    logic [INST_W-1:0]   inst_nxt;
    logic                err_q;
    logic                err_nxt;
    logic                load_pc;
    logic                req_ready_q;
    logic                rsp_valid_q;
    logic                mem_req_valid_q;
    logic [ADDR_W:0]     pc_ext;
    logic                pc_ok;
    logic                tmo_hit;
    logic                drain_after;

    assign pc_ext = {1'b0, req_pc};
    assign pc_ok  = (req_pc[1:0] == 2'b00) && (pc_ext >= LO_EXT) && (pc_ext < HI_EXT);

`ifdef YSYX_23060061_IFU_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] tmo_q;
    logic             drain_pend_q;

    assign tmo_hit     = (state_q == MWAIT) && (tmo_q == CNT_W'(TIMEOUT - 1));
    // A timed-out read still owes us a data beat; swallow it before the next fetch.
    assign drain_after = drain_pend_q && !mem_rsp_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q        <= '0;
            drain_pend_q <= 1'b0;
        end else begin
            if (state_q != MWAIT) begin
                tmo_q <= '0;
            end else begin
                tmo_q <= tmo_q + CNT_W'(1);
            end
            if (tmo_hit && !mem_rsp_valid && !flush) begin
                drain_pend_q <= 1'b1;
            end else if (mem_rsp_valid) begin
                drain_pend_q <= 1'b0;
            end
        end
    end
`else
    assign tmo_hit     = 1'b0;
    assign drain_after = 1'b0;
`endif

    // Next-state and response-payload selection.
    always_comb begin
        state_nxt = state_q;
        load_pc   = 1'b0;
        inst_nxt  = inst_q;
        err_nxt   = err_q;
        unique case (state_q)
            IDLE: begin
                if (!flush && req_valid) begin
                    load_pc = 1'b1;
                    if (pc_ok) begin
                        state_nxt = MREQ;
                    end else begin
                        state_nxt = RESP;
                        inst_nxt  = NOP;
                        err_nxt   = 1'b1;
                    end
                end
            end
            MREQ: begin
                if (flush) begin
                    state_nxt = mem_req_ready ? DRAIN : IDLE;
                end else if (mem_req_ready) begin
                    state_nxt = MWAIT;
                end
            end
            MWAIT: begin
                if (flush) begin
                    state_nxt = mem_rsp_valid ? IDLE : DRAIN;
                end else if (mem_rsp_valid) begin
                    state_nxt = RESP;
                    inst_nxt  = mem_rdata;
                    err_nxt   = 1'b0;
                end else if (tmo_hit) begin
                    state_nxt = RESP;
                    inst_nxt  = NOP;
                    err_nxt   = 1'b1;
                end
            end
            RESP: begin
                if (flush || rsp_ready) begin
                    state_nxt = drain_after ? DRAIN : IDLE;
                end
            end
            DRAIN: begin
                if (mem_rsp_valid) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            req_ready_q     <= 1'b1;
            rsp_valid_q     <= 1'b0;
            mem_req_valid_q <= 1'b0;
        end else begin
            state_q         <= state_nxt;
            req_ready_q     <= (state_nxt == IDLE);
            rsp_valid_q     <= (state_nxt == RESP);
            mem_req_valid_q <= (state_nxt == MREQ);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q   <= '0;
            inst_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (load_pc) begin
                pc_q <= req_pc;
            end
            inst_q <= inst_nxt;
            err_q  <= err_nxt;
        end
    end

    // flush must block acceptance in the same cycle it is raised.
    assign req_ready     = req_ready_q && !flush;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_inst      = inst_q;
    assign rsp_pc        = pc_q;
    assign rsp_err       = err_q;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_addr      = {pc_q[ADDR_W-1:2], 2'b00};

endmodule
